// File: rtl/ifetch_pkg.sv
// ifetch_pkg
// Shared definitions for the instruction-fetch ROM port: the fetch FSM state
// encoding, the NOP delivered when no valid instruction is available, the
// default bus timeout and a word-alignment helper.
// Ports: none (package).
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } ifetch_state_e;

    localparam logic [31:0] INST_NOP               = 32'h0000_0000;
    localparam int          IFETCH_TIMEOUT_DEFAULT = 64;

    // A fetch address is usable only when it points at a whole 32-bit word.
    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/ifetch_rom_port_if.sv
// ifetch_rom_port_if
// Instruction ROM bus: a single-outstanding request/acknowledge handshake.
// Signals:
//   bus_req   - request, held with bus_addr until bus_ack
//   bus_addr  - ROM byte address of the requested word (ADDR_W bits)
//   bus_ack   - data valid / request accepted
//   bus_rdata - 32-bit read data, valid with bus_ack
//   bus_err   - error flag, valid with bus_ack
// Modports: master (fetch port side), slave (ROM side).
interface ifetch_rom_port_if #(
    parameter int ADDR_W = 32
);
    logic              bus_req;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_ack;
    logic [31:0]       bus_rdata;
    logic              bus_err;

    modport master (
        output bus_req,
        output bus_addr,
        input  bus_ack,
        input  bus_rdata,
        input  bus_err
    );

    modport slave (
        input  bus_req,
        input  bus_addr,
        output bus_ack,
        output bus_rdata,
        output bus_err
    );
endinterface

// File: rtl/ifetch_watchdog.sv
// ifetch_watchdog
// Loadable down-counter bounding how long a bus transaction may stay open.
// Ports:
//   clk, rst     - clock, asynchronous active-low reset
//   clear        - synchronous clear of the count
//   load         - load load_val (takes effect at the next edge)
//   load_val     - start value, CNT_W bits
//   enable       - count down while high
//   expired      - high in the last enabled cycle of the loaded interval
// Used by ifetch_rom_port only when IFETCH_TIMEOUT_EN is defined.
module ifetch_watchdog #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             enable,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_r;

    // Down-counter: clear wins over load, load wins over counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (enable && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // A load of N gives exactly N enabled cycles, the Nth one flagged.
    assign expired = enable && (cnt_r == CNT_W'(1));

endmodule

// File: rtl/ifetch_rom_port.sv
// ifetch_rom_port
// Instruction-fetch memory port between the IF stage and the instruction ROM
// bus. Each IF-stage PC is turned into at most one outstanding ROM read; the
// result is kept in a one-entry hold buffer from which the instruction is
// delivered combinationally on a hit.
// Parameters: ADDR_W (fetch address width), TIMEOUT (bus wait bound).
// Ports:
//   clk, rst   - clock, asynchronous active-low reset
//   rom_cs     - fetch enable from the pipeline controller
//   rom_rst    - synchronous flush of the fetch state
//   fetch_addr - PC from the IF stage
//   inst       - instruction to IF/ID (NOP when not valid)
//   rom_stall  - IF must wait for the ROM
//   fetch_err  - delivered instruction is invalid
//   bus        - ROM bus (ifetch_rom_port_if.master)
// Build option: IFETCH_TIMEOUT_EN adds a watchdog that abandons a bus
// transaction after TIMEOUT cycles without bus_ack.
import ifetch_pkg::*;

module ifetch_rom_port #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = IFETCH_TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rom_cs,
    input  logic                rom_rst,
    input  logic [ADDR_W-1:0]   fetch_addr,
    output logic [31:0]         inst,
    output logic                rom_stall,
    output logic                fetch_err,
    ifetch_rom_port_if.master   bus
);

    if (TIMEOUT < 1) begin : g_timeout_range
        $error("ifetch_rom_port: TIMEOUT must be at least 1");
    end

    ifetch_state_e     state_r, state_n;
    logic              hold_valid_r, hold_valid_n;
    logic [ADDR_W-1:0] hold_addr_r, hold_addr_n;
    logic [31:0]       hold_data_r, hold_data_n;
    logic              hold_err_r, hold_err_n;
    logic              bus_req_r, bus_req_n;
    logic [ADDR_W-1:0] bus_addr_r, bus_addr_n;

    logic              hit_s;
    logic              aligned_s;
    logic              miss_s;
    logic              timeout_s;

    assign hit_s     = hold_valid_r && (hold_addr_r == fetch_addr);
    assign aligned_s = is_word_aligned(fetch_addr[1:0]);
    assign miss_s    = rom_cs && !hit_s && aligned_s;

`ifdef IFETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic wd_load_s;
    logic wd_run_s;
    logic wd_clear_s;

    // The count starts with the request and keeps running through DRAIN, so a
    // flushed transaction is bounded by the same budget as the original one.
    assign wd_run_s   = (state_r == WAIT) || (state_r == DRAIN);
    assign wd_load_s  = (state_r == IDLE) && (state_n == WAIT);
    assign wd_clear_s = (state_n == IDLE);

    ifetch_watchdog #(
        .CNT_W (CNT_W)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear    (wd_clear_s),
        .load     (wd_load_s),
        .load_val (CNT_W'(TIMEOUT)),
        .enable   (wd_run_s),
        .expired  (timeout_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // State, hold buffer and bus request registers; reset drops bus_req at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            hold_valid_r <= 1'b0;
            hold_addr_r  <= {ADDR_W{1'b0}};
            hold_data_r  <= INST_NOP;
            hold_err_r   <= 1'b0;
            bus_req_r    <= 1'b0;
            bus_addr_r   <= {ADDR_W{1'b0}};
        end else begin
            state_r      <= state_n;
            hold_valid_r <= hold_valid_n;
            hold_addr_r  <= hold_addr_n;
            hold_data_r  <= hold_data_n;
            hold_err_r   <= hold_err_n;
            bus_req_r    <= bus_req_n;
            bus_addr_r   <= bus_addr_n;
        end
    end

    // Fetch FSM next-state and hold-buffer update.
    always_comb begin
        state_n      = state_r;
        hold_valid_n = hold_valid_r;
        hold_addr_n  = hold_addr_r;
        hold_data_n  = hold_data_r;
        hold_err_n   = hold_err_r;
        bus_req_n    = bus_req_r;
        bus_addr_n   = bus_addr_r;

        if (rom_rst) begin
            hold_valid_n = 1'b0;
        end else begin
            hold_valid_n = hold_valid_r;
        end

        case (state_r)
            IDLE: begin
                // A flush cycle never launches a request.
                if (!rom_rst && miss_s) begin
                    bus_req_n  = 1'b1;
                    bus_addr_n = fetch_addr;
                    state_n    = WAIT;
                end else begin
                    state_n    = IDLE;
                end
            end
            WAIT: begin
                if (bus.bus_ack) begin
                    // Data is filed under the address it was fetched for,
                    // even if the PC has moved on meanwhile.
                    bus_req_n = 1'b0;
                    state_n   = IDLE;
                    if (!rom_rst) begin
                        hold_valid_n = 1'b1;
                        hold_addr_n  = bus_addr_r;
                        hold_data_n  = bus.bus_rdata;
                        hold_err_n   = bus.bus_err;
                    end else begin
                        hold_valid_n = 1'b0;
                    end
                end else if (timeout_s) begin
                    // Abandoned fetch becomes an error entry for that PC.
                    bus_req_n = 1'b0;
                    state_n   = IDLE;
                    if (!rom_rst) begin
                        hold_valid_n = 1'b1;
                        hold_addr_n  = bus_addr_r;
                        hold_data_n  = INST_NOP;
                        hold_err_n   = 1'b1;
                    end else begin
                        hold_valid_n = 1'b0;
                    end
                end else if (rom_rst) begin
                    // The request cannot be withdrawn; wait it out in DRAIN.
                    state_n = DRAIN;
                end else begin
                    state_n = WAIT;
                end
            end
            DRAIN: begin
                if (bus.bus_ack || timeout_s) begin
                    bus_req_n = 1'b0;
                    state_n   = IDLE;
                end else begin
                    state_n   = DRAIN;
                end
            end
            default: begin
                bus_req_n = 1'b0;
                state_n   = IDLE;
            end
        endcase
    end

    assign bus.bus_req  = bus_req_r;
    assign bus.bus_addr = bus_addr_r;

    // Stall is forced low during reset since the hold buffer is being cleared.
    assign rom_stall = rst && miss_s;
    assign inst      = (hit_s && !hold_err_r) ? hold_data_r : INST_NOP;
    assign fetch_err = rom_cs && ((hit_s && hold_err_r) || !aligned_s);

endmodule
